// File: rtl/ll_pkg.sv
// Shared parameters and types for the linked-list dequeue scheduler.
package ll_pkg;

  localparam int NUM_QUEUES = 4;
  localparam int LL_DEPTH   = 64;
  localparam int DATA_WIDTH = 6;
  localparam int READ_DELAY = 3;
  localparam int ISSUE_GAP  = 1;

  localparam int QW     = $clog2(NUM_QUEUES);
  localparam int CW     = $clog2(LL_DEPTH + 1);
  localparam int GW     = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam int PIPE_D = READ_DELAY + 1;

  typedef logic [QW-1:0]         qid_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [GW-1:0]         gap_t;

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} sched_state_e;

  function automatic qid_t wrap_inc(qid_t q);
    if (int'(q) == NUM_QUEUES - 1) return '0;
    return q + 1'b1;
  endfunction

endpackage

// File: rtl/ll_deq_scheduler_if.sv
// Enqueue, dequeue-issue, response and occupancy signals of the scheduler.
interface ll_deq_scheduler_if;
  import ll_pkg::*;

  logic                     init_done_in;
  logic                     enq_vld_in;
  qid_t                     enq_id_in;
  data_t                    enq_data_in;
  logic                     enq_rdy_out;
  logic                     ll_enq_vld_out;
  qid_t                     ll_enq_id_out;
  data_t                    ll_enq_data_out;
  logic [NUM_QUEUES-1:0]    deq_req_in;
  logic [NUM_QUEUES-1:0]    deq_gnt_out;
  logic                     ll_deq_vld_out;
  qid_t                     ll_deq_id_out;
  data_t                    ll_deq_data_in;
  logic                     rsp_vld_out;
  qid_t                     rsp_id_out;
  data_t                    rsp_data_out;
  logic [NUM_QUEUES*CW-1:0] queue_cnt_out;
  cnt_t                     global_cnt_out;

  modport master (
    output init_done_in, enq_vld_in, enq_id_in, enq_data_in, deq_req_in, ll_deq_data_in,
    input  enq_rdy_out, ll_enq_vld_out, ll_enq_id_out, ll_enq_data_out, deq_gnt_out,
           ll_deq_vld_out, ll_deq_id_out, rsp_vld_out, rsp_id_out, rsp_data_out,
           queue_cnt_out, global_cnt_out
  );

  modport slave (
    input  init_done_in, enq_vld_in, enq_id_in, enq_data_in, deq_req_in, ll_deq_data_in,
    output enq_rdy_out, ll_enq_vld_out, ll_enq_id_out, ll_enq_data_out, deq_gnt_out,
           ll_deq_vld_out, ll_deq_id_out, rsp_vld_out, rsp_id_out, rsp_data_out,
           queue_cnt_out, global_cnt_out
  );

endinterface

// File: rtl/ll_rr_arbiter.sv
// Combinational arbiter: first request at or after ptr_i wins.
// Define LL_SCHED_STRICT_PRIO_EN for fixed priority (lowest index wins, ptr_i ignored).
module ll_rr_arbiter
  import ll_pkg::*;
(
  input  logic [NUM_QUEUES-1:0] req_i,
  input  qid_t                  ptr_i,
  output logic [NUM_QUEUES-1:0] gnt_o,
  output qid_t                  idx_o,
  output logic                  any_o
);

  always_comb begin
    int k;
    k     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
`ifdef LL_SCHED_STRICT_PRIO_EN
      k = i;
`else
      k = int'(ptr_i) + i;
      if (k >= NUM_QUEUES) k = k - NUM_QUEUES;
`endif
      if (!any_o && req_i[k]) begin
        any_o = 1'b1;
        idx_o = qid_t'(k);
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

`ifdef LL_SCHED_STRICT_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

endmodule

// File: rtl/ll_deq_scheduler.sv
// Occupancy tracking, enqueue gating and dequeue issue in front of the multi-queue linked list.
// LL_SCHED_STRICT_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module ll_deq_scheduler
  import ll_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ll_deq_scheduler_if.slave  bus
);

  localparam logic [0:0] ST_INIT = 1'(INIT);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

  logic [0:0]            state_q, state_d;
  cnt_t                  cnt_q [NUM_QUEUES];
  cnt_t                  cnt_d [NUM_QUEUES];
  cnt_t                  global_cnt_q, global_cnt_d;
  qid_t                  rr_ptr_q, rr_ptr_d;
  gap_t                  gap_q, gap_d;
  logic                  ll_deq_vld_q, ll_deq_vld_d;
  qid_t                  ll_deq_id_q, ll_deq_id_d;
  logic [NUM_QUEUES-1:0] deq_gnt_q, deq_gnt_d;
  logic [PIPE_D-1:0]     pipe_vld_q, pipe_vld_d;
  qid_t                  pipe_id_q [PIPE_D];
  qid_t                  pipe_id_d [PIPE_D];

  logic                  run;
  logic                  enq_rdy;
  logic                  enq_acc;
  logic [NUM_QUEUES-1:0] eligible;
  logic [NUM_QUEUES-1:0] arb_req;
  logic [NUM_QUEUES-1:0] arb_gnt;
  qid_t                  arb_idx;
  logic                  issue;
  logic [NUM_QUEUES*CW-1:0] cnt_flat;

  assign run     = (state_q == ST_RUN);
  assign enq_rdy = run && (global_cnt_q != cnt_t'(LL_DEPTH));
  assign enq_acc = bus.enq_vld_in && enq_rdy;

  // Eligibility uses registered counts only, so a same-cycle enqueue cannot enable an issue.
  always_comb begin
    eligible = '0;
    for (int q = 0; q < NUM_QUEUES; q++)
      eligible[q] = bus.deq_req_in[q] && (cnt_q[q] != '0);
  end

  assign arb_req = (run && gap_q == '0) ? eligible : '0;

  ll_rr_arbiter u_arb (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (issue)
  );

  always_comb begin
    state_d      = state_q;
    global_cnt_d = global_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    ll_deq_vld_d = issue;
    ll_deq_id_d  = issue ? arb_idx : '0;
    deq_gnt_d    = arb_gnt;
    gap_d        = issue ? gap_t'(ISSUE_GAP) : ((gap_q != '0) ? gap_q - 1'b1 : gap_q);

    for (int q = 0; q < NUM_QUEUES; q++) begin
      cnt_d[q] = cnt_q[q];
      if (enq_acc && bus.enq_id_in == qid_t'(q) && !(issue && arb_idx == qid_t'(q)))
        cnt_d[q] = cnt_q[q] + 1'b1;
      else if (issue && arb_idx == qid_t'(q) && !(enq_acc && bus.enq_id_in == qid_t'(q)))
        cnt_d[q] = cnt_q[q] - 1'b1;
    end

    if (enq_acc && !issue)
      global_cnt_d = global_cnt_q + 1'b1;
    else if (issue && !enq_acc)
      global_cnt_d = global_cnt_q - 1'b1;

`ifdef LL_SCHED_STRICT_PRIO_EN
    rr_ptr_d = '0;
`else
    if (issue) rr_ptr_d = wrap_inc(arb_idx);
`endif

    pipe_vld_d   = {pipe_vld_q[PIPE_D-2:0], ll_deq_vld_q};
    pipe_id_d[0] = ll_deq_id_q;
    for (int i = 1; i < PIPE_D; i++)
      pipe_id_d[i] = pipe_id_q[i-1];

    case (state_q)
      ST_INIT: begin
        if (bus.init_done_in) state_d = ST_RUN;
      end
      default: begin
        // Losing init means the list is being rebuilt: forget occupancy and in-flight reads.
        if (!bus.init_done_in) begin
          state_d      = ST_INIT;
          global_cnt_d = '0;
          gap_d        = '0;
          ll_deq_vld_d = 1'b0;
          ll_deq_id_d  = '0;
          deq_gnt_d    = '0;
          pipe_vld_d   = '0;
          for (int q = 0; q < NUM_QUEUES; q++) cnt_d[q] = '0;
          for (int i = 0; i < PIPE_D; i++) pipe_id_d[i] = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      global_cnt_q <= '0;
      rr_ptr_q     <= '0;
      gap_q        <= '0;
      ll_deq_vld_q <= 1'b0;
      ll_deq_id_q  <= '0;
      deq_gnt_q    <= '0;
      pipe_vld_q   <= '0;
      for (int q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= '0;
      for (int i = 0; i < PIPE_D; i++) pipe_id_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      global_cnt_q <= global_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      gap_q        <= gap_d;
      ll_deq_vld_q <= ll_deq_vld_d;
      ll_deq_id_q  <= ll_deq_id_d;
      deq_gnt_q    <= deq_gnt_d;
      pipe_vld_q   <= pipe_vld_d;
      for (int q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= cnt_d[q];
      for (int i = 0; i < PIPE_D; i++) pipe_id_q[i] <= pipe_id_d[i];
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int q = 0; q < NUM_QUEUES; q++)
      cnt_flat[q*CW +: CW] = cnt_q[q];
  end

  assign bus.enq_rdy_out     = enq_rdy;
  assign bus.ll_enq_vld_out  = enq_acc;
  assign bus.ll_enq_id_out   = bus.enq_id_in;
  assign bus.ll_enq_data_out = bus.enq_data_in;
  assign bus.deq_gnt_out     = deq_gnt_q;
  assign bus.ll_deq_vld_out  = ll_deq_vld_q;
  assign bus.ll_deq_id_out   = ll_deq_id_q;
  assign bus.rsp_vld_out     = pipe_vld_q[PIPE_D-1];
  assign bus.rsp_id_out      = pipe_id_q[PIPE_D-1];
  assign bus.rsp_data_out    = bus.ll_deq_data_in;
  assign bus.queue_cnt_out   = cnt_flat;
  assign bus.global_cnt_out  = global_cnt_q;

endmodule

// File: tb/tb_ll_deq_scheduler.sv
// Directed bench for ll_deq_scheduler with a linked-list data model and response scoreboard.
module tb_ll_deq_scheduler;
  import ll_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ll_deq_scheduler_if bus ();

  ll_deq_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int    id;
    int    data;
    int    due;
  } exp_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    rsp_seen = 0;
  data_t llq [NUM_QUEUES][$];
  exp_t  sb [$];
  data_t data_at [int];
  int    iss_id [$];
  int    iss_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int qcnt(int q);
    return int'(bus.queue_cnt_out[q*CW +: CW]);
  endfunction

  // Linked-list read port model: data appears READ_DELAY+1 cycles after the issue.
  always begin
    bus.ll_deq_data_in = data_at.exists(cyc) ? data_at[cyc] : '0;
    @(posedge clk);
    #1;
  end

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      data_at.delete();
      for (int q = 0; q < NUM_QUEUES; q++) llq[q].delete();
    end else begin
      if (bus.ll_enq_vld_out) llq[int'(bus.ll_enq_id_out)].push_back(bus.ll_enq_data_out);
      if (bus.ll_deq_vld_out) begin
        exp_t e;
        int id;
        id = int'(bus.ll_deq_id_out);
        chk("gnt_onehot", int'(bus.deq_gnt_out), 1 << id);
        e.id   = id;
        e.data = (llq[id].size() > 0) ? int'(llq[id].pop_front()) : 0;
        e.due  = cyc + READ_DELAY + 1;
        sb.push_back(e);
        data_at[e.due] = data_t'(e.data);
        iss_id.push_back(id);
        iss_cyc.push_back(cyc);
      end
      if (bus.rsp_vld_out) begin
        rsp_seen++;
        chk("rsp_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", int'(bus.rsp_id_out), e.id);
          chk("rsp_data", int'(bus.rsp_data_out), e.data);
          chk("rsp_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic enq(int id, int data);
    bus.enq_vld_in  = 1'b1;
    bus.enq_id_in   = qid_t'(id);
    bus.enq_data_in = data_t'(data);
    tick();
    bus.enq_vld_in  = 1'b0;
  endtask

  task automatic wait_issues(int n, int budget, string tag);
    int k = 0;
    while (iss_id.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, iss_id.size(), n);
  endtask

  task automatic wait_rsp(int n, int budget, string tag);
    int k = 0;
    while (rsp_seen < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, rsp_seen, n);
  endtask

  task automatic do_reset;
    chk("sb_drained", sb.size(), 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int base;
    int exp_order [12];
    bus.init_done_in = 1'b0;
    bus.enq_vld_in   = 1'b0;
    bus.enq_id_in    = '0;
    bus.enq_data_in  = '0;
    bus.deq_req_in   = '0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_enq_rdy", int'(bus.enq_rdy_out), 0);
    chk("rst_deq_vld", int'(bus.ll_deq_vld_out), 0);
    chk("rst_rsp_vld", int'(bus.rsp_vld_out), 0);
    chk("rst_global", int'(bus.global_cnt_out), 0);
    chk("rst_gnt", int'(bus.deq_gnt_out), 0);

    // 1: INIT holds off enqueue and issue
    tick();
    reset = 1'b0;
    bus.enq_vld_in  = 1'b1;
    bus.enq_id_in   = 2'd1;
    bus.enq_data_in = 6'd5;
    bus.deq_req_in  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("init_enq_rdy", int'(bus.enq_rdy_out), 0);
      chk("init_ll_enq", int'(bus.ll_enq_vld_out), 0);
      chk("init_deq_vld", int'(bus.ll_deq_vld_out), 0);
      tick();
    end
    bus.enq_vld_in   = 1'b0;
    bus.deq_req_in   = '0;
    bus.init_done_in = 1'b1;
    @(negedge clk);
    chk("init_rdy_same_cycle", int'(bus.enq_rdy_out), 0);
    tick();
    @(negedge clk);
    chk("run_enq_rdy", int'(bus.enq_rdy_out), 1);

    // 2: two entries through q0
    tick();
    enq(0, 1);
    enq(0, 2);
    @(negedge clk);
    chk("t2_cnt0_loaded", qcnt(0), 2);
    tick();
    base = iss_id.size();
    bus.deq_req_in = 4'b0001;
    wait_issues(base + 2, 20, "t2_issues");
    bus.deq_req_in = '0;
    chk("t2_id0", iss_id[base], 0);
    chk("t2_id1", iss_id[base+1], 0);
    chk("t2_spacing", iss_cyc[base+1] - iss_cyc[base], ISSUE_GAP + 1);
    wait_rsp(2, 20, "t2_rsp");
    @(negedge clk);
    chk("t2_cnt0_end", qcnt(0), 0);
    chk("t2_global_end", int'(bus.global_cnt_out), 0);

    // 3: arbitration order across all queues
    tick();
    do_reset();
    for (int q = 0; q < NUM_QUEUES; q++)
      for (int k = 0; k < 3; k++)
        enq(q, q * 16 + k + 1);
    @(negedge clk);
    chk("t3_global_loaded", int'(bus.global_cnt_out), 12);
    tick();
    for (int i = 0; i < 12; i++) begin
`ifdef LL_SCHED_STRICT_PRIO_EN
      exp_order[i] = i / 3;
`else
      exp_order[i] = i % 4;
`endif
    end
    base = iss_id.size();
    bus.deq_req_in = 4'b1111;
    wait_issues(base + 12, 80, "t3_issues");
    bus.deq_req_in = '0;
    for (int i = 0; i < 12; i++) chk("t3_order", iss_id[base+i], exp_order[i]);
    wait_rsp(14, 20, "t3_rsp");
    @(negedge clk);
    chk("t3_global_end", int'(bus.global_cnt_out), 0);

    // 4: global capacity
    tick();
    do_reset();
    for (int i = 0; i < LL_DEPTH; i++) begin
      bus.enq_vld_in  = 1'b1;
      bus.enq_id_in   = qid_t'(i % 4);
      bus.enq_data_in = data_t'((i % 63) + 1);
      @(negedge clk);
      chk("t4_rdy_fill", int'(bus.enq_rdy_out), 1);
      tick();
    end
    bus.enq_vld_in = 1'b0;
    @(negedge clk);
    chk("t4_global_full", int'(bus.global_cnt_out), LL_DEPTH);
    chk("t4_rdy_full", int'(bus.enq_rdy_out), 0);
    tick();
    bus.enq_vld_in  = 1'b1;
    bus.enq_id_in   = 2'd1;
    bus.enq_data_in = 6'd7;
    @(negedge clk);
    chk("t4_65th_blocked", int'(bus.ll_enq_vld_out), 0);
    tick();
    bus.enq_vld_in = 1'b0;
    bus.deq_req_in = 4'b0001;
    @(negedge clk);
    chk("t4_global_held", int'(bus.global_cnt_out), LL_DEPTH);
    chk("t4_rdy_same_cycle_deq", int'(bus.enq_rdy_out), 0);
    tick();
    bus.deq_req_in = '0;
    @(negedge clk);
    chk("t4_global_drop", int'(bus.global_cnt_out), LL_DEPTH - 1);
    chk("t4_rdy_after_drop", int'(bus.enq_rdy_out), 1);
    wait_rsp(15, 20, "t4_rsp");

    // 5: enqueue and issue on the same queue in one cycle
    tick();
    do_reset();
    enq(2, 9);
    @(negedge clk);
    chk("t5_cnt2_loaded", qcnt(2), 1);
    tick();
    bus.enq_vld_in  = 1'b1;
    bus.enq_id_in   = 2'd2;
    bus.enq_data_in = 6'd10;
    bus.deq_req_in  = 4'b0100;
    @(negedge clk);
    chk("t5_enq_accepted", int'(bus.ll_enq_vld_out), 1);
    tick();
    bus.enq_vld_in = 1'b0;
    bus.deq_req_in = '0;
    @(negedge clk);
    chk("t5_issue_vld", int'(bus.ll_deq_vld_out), 1);
    chk("t5_issue_id", int'(bus.ll_deq_id_out), 2);
    chk("t5_cnt2", qcnt(2), 1);
    chk("t5_global", int'(bus.global_cnt_out), 1);
    wait_rsp(16, 20, "t5_rsp");

    // 6: reset with a response in flight
    tick();
    bus.deq_req_in = 4'b0100;
    tick();
    bus.deq_req_in = '0;
    @(negedge clk);
    chk("t6_issue_vld", int'(bus.ll_deq_vld_out), 1);
    tick();
    tick();
    reset = 1'b1;
    bus.init_done_in = 1'b0;
    @(negedge clk);
    chk("t6_rst_rsp_vld", int'(bus.rsp_vld_out), 0);
    chk("t6_rst_deq_vld", int'(bus.ll_deq_vld_out), 0);
    chk("t6_rst_global", int'(bus.global_cnt_out), 0);
    chk("t6_rst_cnt2", qcnt(2), 0);
    chk("t6_rst_rdy", int'(bus.enq_rdy_out), 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", int'(bus.rsp_vld_out), 0);
      chk("t6_fsm_init", int'(bus.enq_rdy_out), 0);
      tick();
    end
    chk("t6_rsp_total", rsp_seen, 16);
    bus.init_done_in = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_rerun_rdy", int'(bus.enq_rdy_out), 1);
    chk("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
